mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_unit_pkg.sv | 36 +++
 rtl/mdu_unit_shift_core.sv | 52 +++++
 rtl/mdu_unit.sv | 135 +++++++++++++
 tb/tb_mdu_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared processor package: multiply/divide op encodings, iteration count,
// FSM state type and small operand helpers.
package mdu_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MDU_ITERATIONS = 32;
  localparam int CNT_W          = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXUP
  } mdu_state_t;

  // Ops that run through the iterative datapath
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that interpret their operands as two's complement
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Absolute value for signed ops, pass-through for unsigned ones
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_unit_shift_core.sv
// Radix-2 iterative datapath on 32-bit magnitudes: shift-add multiply and
// restoring shift-subtract divide, one iteration per step pulse.
module mdu_shift_core
  import mdu_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        div_mode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] acc_hi,
  output logic [31:0] acc_lo
);

  logic [31:0] operand_b;
  logic [32:0] mul_sum;
  logic [32:0] div_rem;
  logic [31:0] div_sub;
  logic        div_ge;

  // Next-iteration candidates for both multiply and divide
  always_comb begin
    mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand_b : 32'd0)};
    div_rem = {acc_hi, acc_lo[31]};
    div_ge  = (div_rem >= {1'b0, operand_b});
    div_sub = div_rem[31:0] - operand_b;
  end

  // Accumulator pair: {product} for multiply, {remainder, quotient} for divide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
    end else if (load) begin
      acc_hi    <= '0;
      acc_lo    <= a;
      operand_b <= b;
    end else if (step) begin
      if (div_mode) begin
        acc_hi <= div_ge ? div_sub : div_rem[31:0];
        acc_lo <= {acc_lo[30:0], div_ge};
      end else begin
        acc_hi <= mul_sum[32:1];
        acc_lo <= {mul_sum[0], acc_lo[31:1]};
      end
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit: FSM, operand sign handling and the HI/LO registers
// around the iterative shift core.
module mdu_unit
  import mdu_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t       state;
  logic [CNT_W-1:0] counter;
  logic             is_div_r;
  logic             neg_q;
  logic             neg_r;
  logic             div0_r;
  logic [31:0]      dividend_r;

  logic             idle_req;
  logic             accept_long;
  logic             accept_move;
  logic             op_signed;
  logic [31:0]      a_mag;
  logic [31:0]      b_mag;
  logic [31:0]      acc_hi;
  logic [31:0]      acc_lo;
  logic [63:0]      prod_fix;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  // Request decode in IDLE; a simultaneous cancel drops the start
  always_comb begin
    idle_req    = (state == ST_IDLE) && start && !cancel;
    accept_long = idle_req && is_long_op(op);
    accept_move = idle_req && ((op == OP_MTHI) || (op == OP_MTLO));
    op_signed   = is_signed_op(op);
    a_mag       = magnitude(rs_val, op_signed);
    b_mag       = magnitude(rt_val, op_signed);
  end

  mdu_shift_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_long),
    .step     (state == ST_CALC),
    .div_mode (is_div_r),
    .a        (a_mag),
    .b        (b_mag),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo)
  );

  // Sign correction of the magnitude result; divide by zero bypasses it
  always_comb begin
    prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div_r) begin
      if (div0_r) begin
        res_hi = dividend_r;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg_r ? -acc_hi : acc_hi;
        res_lo = neg_q ? -acc_lo : acc_lo;
      end
    end
  end

  // Control FSM with registered busy/done and the HI/LO architectural registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      counter    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      is_div_r   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div0_r     <= 1'b0;
      dividend_r <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_long) begin
            state      <= ST_CALC;
            busy       <= 1'b1;
            counter    <= '0;
            is_div_r   <= op[1];
            neg_q      <= op_signed && (rs_val[31] ^ rt_val[31]);
            neg_r      <= op_signed && rs_val[31];
            div0_r     <= op[1] && (rt_val == 32'd0);
            dividend_r <= rs_val;
          end else if (accept_move) begin
            if (op == OP_MTHI) hi <= rs_val;
            else               lo <= rs_val;
          end
        end
        ST_CALC: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
            if (counter == CNT_W'(MDU_ITERATIONS - 1)) state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: scoreboard of expected {hi,lo} results
// pushed at issue and popped when done pulses.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;
  logic [63:0] sb[$];

  mdu_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Count done pulses (value held during the cycle ending at this edge)
  always @(posedge clk) if (done === 1'b1) done_count++;

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference {hi,lo} from language-level arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sbv, q, r;
    logic [63:0] up;
    sa = a; sbv = b;
    case (o)
      OP_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output bit ok);
    lat = lat0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    ok = (done === 1'b1);
  endtask

  // One full MULT/DIV transaction checked against the scoreboard
  task automatic do_long_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat; bit ok; int dc0; logic [63:0] exp;
    dc0 = done_count;
    sb.push_back(model(o, a, b));
    issue(o, a, b);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_busy: got %b want 1", name, busy); end
    wait_done(1, lat, ok);
    vectors++;
    if (!ok || lat != 34) begin miscompares++; $display("[TB] FAIL %s_latency: got %0d (done=%b) want 34", name, lat, done); end
    exp = sb.pop_front();
    vectors++;
    if ({hi, lo} !== exp) begin miscompares++; $display("[TB] FAIL %s_result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || done_count != dc0 + 1) begin
      miscompares++;
      $display("[TB] FAIL %s_pulse: got done=%b busy=%b pulses=%0d want done=0 busy=0 pulses=1", name, done, busy, done_count - dc0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = OP_MULT; rs_val = '0; rt_val = '0;
    #12;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done); end
    vectors++;
    if ({hi, lo} !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_hilo: got hi=%h lo=%h want 0 0", hi, lo); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mult();
    do_long_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    vectors++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin miscompares++; $display("[TB] FAIL mult_const: got %h%h want FFFFFFFFFFFFFFFA", hi, lo); end
    do_long_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    vectors++;
    if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin miscompares++; $display("[TB] FAIL multu_const: got %h%h want 00000002FFFFFFFA", hi, lo); end
    do_long_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_div();
    do_long_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    vectors++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin miscompares++; $display("[TB] FAIL div_const: got hi=%h lo=%h want FFFFFFFF FFFFFFFD", hi, lo); end
    do_long_op("divu", OP_DIVU, 32'd7, 32'd2);
    do_long_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    vectors++;
    if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin miscompares++; $display("[TB] FAIL div_ovf_const: got hi=%h lo=%h want 0 80000000", hi, lo); end
    do_long_op("divu_zero", OP_DIVU, 32'd5, 32'd0);
    do_long_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF0, 32'd0);
    do_long_op("div_posneg", OP_DIV, 32'd100, 32'hFFFF_FFF9);
  endtask

  task automatic test_random();
    logic [2:0] o; logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      do_long_op("random", o, a, b);
    end
  endtask

  task automatic test_move();
    int dc0;
    dc0 = done_count;
    issue(OP_MTHI, 32'h0000_AAAA, 32'd0);
    vectors++;
    if (hi !== 32'h0000_AAAA || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mthi: got hi=%h busy=%b want 0000aaaa 0", hi, busy); end
    issue(OP_MTLO, 32'h0000_5555, 32'd0);
    @(negedge clk);
    vectors++;
    if (lo !== 32'h0000_5555 || hi !== 32'h0000_AAAA || busy !== 1'b0 || done_count != dc0) begin
      miscompares++;
      $display("[TB] FAIL mtlo: got hi=%h lo=%h busy=%b pulses=%0d want 0000aaaa 00005555 0 0", hi, lo, busy, done_count - dc0);
    end
  endtask

  task automatic test_busy_ignore();
    int lat; bit ok; int dc0; logic [63:0] exp;
    dc0 = done_count;
    sb.push_back(model(OP_MULT, 32'h0001_2345, 32'h0000_6789));
    issue(OP_MULT, 32'h0001_2345, 32'h0000_6789);
    lat = 1;
    repeat (8) begin @(negedge clk); lat++; end
    op = OP_MTHI; rs_val = 32'h0000_1234; start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || hi !== 32'h0000_AAAA) begin miscompares++; $display("[TB] FAIL busy_ignore_mid: got busy=%b hi=%h want 1 0000aaaa", busy, hi); end
    wait_done(lat, lat, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || lat != 34 || {hi, lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL busy_ignore_result: got lat=%0d hi=%h lo=%h want 34 %h %h", lat, hi, lo, exp[63:32], exp[31:0]);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done_count != dc0 + 1) begin miscompares++; $display("[TB] FAIL busy_ignore_pulses: got %0d want 1", done_count - dc0); end
  endtask

  task automatic test_cancel();
    int dc0;
    issue(OP_MTHI, 32'h0000_AAAA, 32'd0);
    issue(OP_MTLO, 32'h0000_5555, 32'd0);
    dc0 = done_count;
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_busy: got %b want 0", busy); end
    repeat (40) @(negedge clk);
    vectors++;
    if (done_count != dc0 || {hi, lo} !== {32'h0000_AAAA, 32'h0000_5555}) begin
      miscompares++;
      $display("[TB] FAIL cancel_hold: got pulses=%0d hi=%h lo=%h want 0 0000aaaa 00005555", done_count - dc0, hi, lo);
    end
    // cancel together with start in IDLE drops the start
    cancel = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    vectors++;
    if (hi !== 32'h0000_AAAA || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_start: got hi=%h busy=%b want 0000aaaa 0", hi, busy); end
    // undefined op code is ignored
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    issue(3'd7, 32'h3333_3333, 32'h4444_4444);
    vectors++;
    if (busy !== 1'b0 || {hi, lo} !== {32'h0000_AAAA, 32'h0000_5555}) begin
      miscompares++;
      $display("[TB] FAIL undefined_op: got busy=%b hi=%h lo=%h want 0 0000aaaa 00005555", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit ok; logic [63:0] exp;
    sb.push_back(model(OP_DIVU, 32'd1000, 32'd33));
    issue(OP_DIVU, 32'd1000, 32'd33);
    wait_done(1, lat, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || {hi, lo} !== exp) begin miscompares++; $display("[TB] FAIL b2b_first: got hi=%h lo=%h want %h %h", hi, lo, exp[63:32], exp[31:0]); end
    sb.push_back(model(OP_MULT, 32'hFFFF_8000, 32'h0000_7FFF));
    op = OP_MULT; rs_val = 32'hFFFF_8000; rt_val = 32'h0000_7FFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, ok);
    exp = sb.pop_front();
    vectors++;
    if (!ok || lat != 34 || {hi, lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got lat=%0d hi=%h lo=%h want 34 %h %h", lat, hi, lo, exp[63:32], exp[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc0;
    issue(OP_MULT, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b1;
    dc0 = done_count;
    repeat (40) @(negedge clk);
    vectors++;
    if (done_count != dc0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release: got pulses=%0d busy=%b want 0 0", done_count - dc0, busy); end
    do_long_op("multu_after_reset", OP_MULTU, 32'd3, 32'd4);
    vectors++;
    if (lo !== 32'd12 || hi !== 32'd0) begin miscompares++; $display("[TB] FAIL multu_12: got hi=%h lo=%h want 0 0000000c", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_move();
    test_busy_ignore();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
